issue_unit_rr: RTL

Warp issue stage that sits between the per-warp instruction buffer/scoreboard array and the operand collector (OC).
- Each cycle it picks at most one ready warp by round-robin arbitration and drives a one-hot grant back to the buffer array.
- It captures the granted instruction fields into a single issue register and hands them to the OC with a valid/ready handshake.
- After a warp issues a branch, that warp is blocked from issue until the branch resolves.

---
 rtl/issue_unit_rr_pkg.sv | 29 ++
 rtl/issue_unit_rr_rr_arbiter8.sv | 32 +++
 rtl/issue_unit_rr.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/issue_unit_rr_pkg.sv
// Shared widths and the packed issue-instruction bundle for the warp issue stage.
package issue_unit_rr_pkg;

    localparam int NUM_WARPS = 8;
    localparam int WID_W     = 3;
    localparam int REG_W     = 6;
    localparam int IMM_W     = 16;
    localparam int OPC_W     = 4;
    localparam int MASK_W    = 8;
    localparam int SBE_W     = 2;

    typedef struct packed {
        logic [REG_W-1:0]  src1;
        logic [REG_W-1:0]  src2;
        logic [REG_W-1:0]  dst;
        logic [IMM_W-1:0]  imme_addr;
        logic [OPC_W-1:0]  alu_opcode;
        logic [MASK_W-1:0] active_mask;
        logic [SBE_W-1:0]  sb_entnum;
        logic              reg_write;
        logic              mem_write;
        logic              mem_read;
        logic              share_globalbar;
        logic              imme_valid;
        logic              beq;
        logic              blt;
    } issue_instr_t;

endpackage

// File: rtl/issue_unit_rr_rr_arbiter8.sv
// Combinational 8-way round-robin pick: rotate by ptr, take lowest set bit, rotate back.
module rr_arbiter8
    import issue_unit_rr_pkg::*;
(
    input  logic [NUM_WARPS-1:0] req,
    input  logic [WID_W-1:0]     ptr,
    output logic [NUM_WARPS-1:0] grant,
    output logic [WID_W-1:0]     idx
);

    logic [2*NUM_WARPS-1:0] req_dbl;
    logic [NUM_WARPS-1:0]   req_rot;
    logic [WID_W-1:0]       pick;
    logic                   found;

    // Rotate so ptr sits at bit 0, priority-pick lowest bit, then add ptr back.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[ptr +: NUM_WARPS];
        found   = 1'b0;
        pick    = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found = 1'b1;
                pick  = WID_W'(i);
            end
        end
        idx   = pick + ptr;
        grant = found ? (NUM_WARPS'(1) << idx) : '0;
    end

endmodule

// File: rtl/issue_unit_rr.sv
// Warp issue stage: round-robin pick of a ready warp, single issue register toward
// the operand collector, and per-warp branch lock until the branch resolves.
module issue_unit_rr
    import issue_unit_rr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_WARPS-1:0]  IB_Ready_Issue_IU,
    output logic [NUM_WARPS-1:0]  IU_Grant,
    input  logic [REG_W-1:0]      Src1_In,
    input  logic [REG_W-1:0]      Src2_In,
    input  logic [REG_W-1:0]      Dst_In,
    input  logic [IMM_W-1:0]      Imme_Addr_In,
    input  logic [OPC_W-1:0]      ALU_Opcode_In,
    input  logic [MASK_W-1:0]     Active_Mask_In,
    input  logic [SBE_W-1:0]      SB_EntNum_In,
    input  logic                  RegWrite_In,
    input  logic                  MemWrite_In,
    input  logic                  MemRead_In,
    input  logic                  Share_Globalbar_In,
    input  logic                  Imme_Valid_In,
    input  logic                  BEQ_In,
    input  logic                  BLT_In,
    output logic                  Valid_IU_OC,
    input  logic                  Ready_OC_IU,
    output logic [REG_W-1:0]      Src1_IU_OC,
    output logic [REG_W-1:0]      Src2_IU_OC,
    output logic [REG_W-1:0]      Dst_IU_OC,
    output logic [IMM_W-1:0]      Imme_Addr_IU_OC,
    output logic [OPC_W-1:0]      ALU_Opcode_IU_OC,
    output logic [MASK_W-1:0]     Active_Mask_IU_OC,
    output logic [SBE_W-1:0]      SB_EntNum_IU_OC,
    output logic                  RegWrite_IU_OC,
    output logic                  MemWrite_IU_OC,
    output logic                  MemRead_IU_OC,
    output logic                  Share_Globalbar_IU_OC,
    output logic                  Imme_Valid_IU_OC,
    output logic                  BEQ_IU_OC,
    output logic                  BLT_IU_OC,
    output logic [WID_W-1:0]      WarpID_IU_OC,
    input  logic                  Branch_Resolved,
    input  logic [WID_W-1:0]      Branch_WarpID,
    output logic [NUM_WARPS-1:0]  Branch_Pending
);

    issue_instr_t          instr_q, instr_d, instr_in;
    logic                  valid_q, valid_d;
    logic [WID_W-1:0]      wid_q, wid_d;
    logic [WID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_WARPS-1:0]  pend_q, pend_d;

    logic                  can_load;
    logic [NUM_WARPS-1:0]  arb_req, arb_grant;
    logic [WID_W-1:0]      arb_idx;
    logic                  granted;

    // Arbitration only runs when the issue register can take a new instruction.
    always_comb begin
        can_load = !valid_q || Ready_OC_IU;
        arb_req  = IB_Ready_Issue_IU & ~pend_q & {NUM_WARPS{can_load && !rst}};
    end

    rr_arbiter8 u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Pack incoming fields of the granted warp.
    always_comb begin
        instr_in = '{src1: Src1_In, src2: Src2_In, dst: Dst_In, imme_addr: Imme_Addr_In,
                     alu_opcode: ALU_Opcode_In, active_mask: Active_Mask_In,
                     sb_entnum: SB_EntNum_In, reg_write: RegWrite_In,
                     mem_write: MemWrite_In, mem_read: MemRead_In,
                     share_globalbar: Share_Globalbar_In, imme_valid: Imme_Valid_In,
                     beq: BEQ_In, blt: BLT_In};
    end

    // Next-state for issue register, pointer and branch locks; a branch set beats a same-warp resolve.
    always_comb begin
        granted  = |arb_grant;
        instr_d  = instr_q;
        valid_d  = valid_q;
        wid_d    = wid_q;
        rr_ptr_d = rr_ptr_q;
        pend_d   = pend_q;
        if (Branch_Resolved) begin
            pend_d[Branch_WarpID] = 1'b0;
        end
        if (granted) begin
            instr_d  = instr_in;
            valid_d  = 1'b1;
            wid_d    = arb_idx;
            rr_ptr_d = arb_idx + WID_W'(1);
            if (BEQ_In || BLT_In) begin
                pend_d[arb_idx] = 1'b1;
            end
        end else if (valid_q && Ready_OC_IU) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= '0;
            valid_q  <= 1'b0;
            wid_q    <= '0;
            rr_ptr_q <= '0;
            pend_q   <= '0;
        end else begin
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            wid_q    <= wid_d;
            rr_ptr_q <= rr_ptr_d;
            pend_q   <= pend_d;
        end
    end

    assign IU_Grant              = arb_grant;
    assign Valid_IU_OC           = valid_q;
    assign WarpID_IU_OC          = wid_q;
    assign Branch_Pending        = pend_q;
    assign Src1_IU_OC            = instr_q.src1;
    assign Src2_IU_OC            = instr_q.src2;
    assign Dst_IU_OC             = instr_q.dst;
    assign Imme_Addr_IU_OC       = instr_q.imme_addr;
    assign ALU_Opcode_IU_OC      = instr_q.alu_opcode;
    assign Active_Mask_IU_OC     = instr_q.active_mask;
    assign SB_EntNum_IU_OC       = instr_q.sb_entnum;
    assign RegWrite_IU_OC        = instr_q.reg_write;
    assign MemWrite_IU_OC        = instr_q.mem_write;
    assign MemRead_IU_OC         = instr_q.mem_read;
    assign Share_Globalbar_IU_OC = instr_q.share_globalbar;
    assign Imme_Valid_IU_OC      = instr_q.imme_valid;
    assign BEQ_IU_OC             = instr_q.beq;
    assign BLT_IU_OC             = instr_q.blt;

endmodule
